// File: rtl/drum_pkg.sv
// Shared types and widths for the DRUM multiplier datapaths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package drum_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/drum_mult_arbiter_if.sv
// Requester bank + tagged response channel of the shared DRUM multiplier.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both request and response sides.
interface drum_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  import drum_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [OP_W*N_REQ-1:0] req_x;
  logic [OP_W*N_REQ-1:0] req_y;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  prod_t                 rsp_p;
  logic                  rsp_ready;

  // Client side: offers operands, consumes products.
  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  // Arbiter side: grants operands, produces products.
  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/DRUM6_16_s.sv
// DRUM approximate 16x16 unsigned multiplier, 6-bit dynamic-range mantissas.
// Latency: combinational.
// Backpressure: none.
module DRUM6_16_s
  import drum_pkg::*;
(
  input  op_t   X,
  input  op_t   Y,
  output prod_t P
);

  // Returns {shift[3:0], mantissa[5:0]}. Operands below 64 pass exactly;
  // larger ones keep the 6 bits from the leading one with the LSB forced
  // high to unbias the truncation.
  function automatic logic [9:0] trunc_op(input op_t v);
    logic [3:0] msb;
    logic [3:0] sh;
    op_t        t;
    msb = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (v[i]) msb = 4'(i);
    end
    if (msb < 4'd6) begin
      trunc_op = {4'd0, v[5:0]};
    end else begin
      sh       = msb - 4'd5;
      t        = v >> sh;
      trunc_op = {sh, t[5:1], 1'b1};
    end
  endfunction

  logic [9:0] w_tx;
  logic [9:0] w_ty;
  logic [4:0] w_sh;

  assign w_tx = trunc_op(X);
  assign w_ty = trunc_op(Y);
  assign w_sh = {1'b0, w_tx[9:6]} + {1'b0, w_ty[9:6]};
  assign P    = (PROD_W'(w_tx[5:0]) * PROD_W'(w_ty[5:0])) << w_sh;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter searching upward from ptr+1 with wrap.
// Latency: combinational.
// Backpressure: i_en low forces an empty grant.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic         i_en,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_cand;

  // First pending request after the last winner gets the grant.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = W'((int'(i_ptr) + k) % N);
      if (i_en && !o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drum_mult_arbiter.sv
// Shares one DRUM6_16_s among N_REQ requesters via round-robin grant.
// Latency: grant at edge t -> tagged product valid after edge t+1.
// Backpressure: S2 stalls on rsp_ready low; S1 fills once more, then grants stop.
module drum_mult_arbiter
  import drum_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst,
  drum_mult_arbiter_if.slave bus
);

  logic            r_rst_q;
  logic [ID_W-1:0] r_ptr;
  logic            r_s1_valid;
  op_t             r_s1_x;
  op_t             r_s1_y;
  logic [ID_W-1:0] r_s1_id;
  logic            r_rsp_valid;
  prod_t           r_rsp_p;
  logic [ID_W-1:0] r_rsp_id;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_en;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  op_t              w_x;
  op_t              w_y;
  prod_t            w_p;

  assign w_adv2 = !r_rsp_valid || bus.rsp_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  // No grants while in reset or in the first cycle after it.
  assign w_en   = w_adv1 && !rst && !r_rst_q;

  rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Pick the winner's operand pair out of the packed request buses.
  always_comb begin
    w_x = bus.req_x[OP_W*int'(w_idx) +: OP_W];
    w_y = bus.req_y[OP_W*int'(w_idx) +: OP_W];
  end

  DRUM6_16_s u_drum (
    .X (r_s1_x),
    .Y (r_s1_y),
    .P (w_p)
  );

  // S1: capture the granted pair; a bubble enters whenever S1 advances ungranted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_q    <= 1'b1;
      r_ptr      <= ID_W'(N_REQ - 1);
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_id    <= '0;
    end else begin
      r_rst_q <= 1'b0;
      if (w_adv1) begin
        r_s1_valid <= w_any;
        if (w_any) begin
          r_s1_x  <= w_x;
          r_s1_y  <= w_y;
          r_s1_id <= w_idx;
          r_ptr   <= w_idx;
        end
      end
    end
  end

  // S2: register the product; data only moves when S1 carries a real pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_p     <= '0;
      r_rsp_id    <= '0;
    end else if (w_adv2) begin
      r_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_p  <= w_p;
        r_rsp_id <= r_s1_id;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_p     = r_rsp_p;
  assign bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_drum_mult_arbiter.sv
// Self-checking bench for drum_mult_arbiter with a queue-based reference model.
// Latency: n/a.
// Backpressure: randomized and directed rsp_ready stalls.
module tb_drum_mult_arbiter;

  localparam int N = 4;

  typedef struct {
    int          id;
    logic [31:0] p;
    bit          vis;
  } rsp_t;

  logic clk;
  logic rst;

  drum_mult_arbiter_if #(.N_REQ(N)) bus ();

  drum_mult_arbiter #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   ptr_m  = N - 1;
  bit   prev_rst = 1'b0;
  rsp_t q[$];

  // DRUM6 value approximation: below 64 exact, otherwise keep 6 bits from the
  // leading one with the lowest kept bit set, then scale back up.
  function automatic longint approx(input longint v);
    int s;
    s = 0;
    while ((v >> s) >= 64) s++;
    if (s == 0) return v;
    return ((v >> s) | 1) << s;
  endfunction

  function automatic logic [31:0] drum_ref(input logic [15:0] a, input logic [15:0] b);
    longint r;
    r = approx(longint'(a)) * approx(longint'(b));
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic r, input logic [3:0] v, input logic [63:0] x,
                     input logic [63:0] y, input logic rr);
    logic [3:0] vv;
    logic [3:0] eg;
    bit         exp_rv;
    bit         acc;
    int         gi;
    int         c;
    @(negedge clk);
    vv            = prev_rst ? 4'b0000 : v;
    rst           = r;
    bus.req_valid = vv;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.rsp_ready = rr;
    #1;
    exp_rv = (q.size() > 0) && q[0].vis;
    acc    = !r && ((q.size() < 2) || rr);
    gi     = -1;
    if (acc) begin
      for (int k = 1; k <= N; k++) begin
        c = (ptr_m + k) % N;
        if (gi < 0 && vv[c]) gi = c;
      end
    end
    eg = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      chk("rsp_p", bus.rsp_p, q[0].p);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      ptr_m = N - 1;
    end else begin
      if (exp_rv && rr) void'(q.pop_front());
      if (q.size() > 0) q[0].vis = 1'b1;
      if (gi >= 0) begin
        q.push_back('{id: gi, p: drum_ref(x[16*gi +: 16], y[16*gi +: 16]), vis: 1'b0});
        ptr_m = gi;
      end
    end
    prev_rst = r;
  endtask

  task automatic one(input int id, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {$urandom, $urandom};
    yy = {$urandom, $urandom};
    xx[16*id +: 16] = a;
    yy[16*id +: 16] = b;
    cyc(1'b0, 4'(1 << id), xx, yy, 1'b1);
  endtask

  task automatic rnd(input logic r, input logic [3:0] v, input logic rr);
    cyc(r, v, {$urandom, $urandom}, {$urandom, $urandom}, rr);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;

    // Reset with requests asserted: no grants may leak out.
    for (int i = 0; i < 3; i++) rnd(1'b1, 4'b1111, 1'b1);
    chk("reset_rsp_p", bus.rsp_p, 32'h0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
    rnd(1'b0, 4'b0000, 1'b1);

    // Single request from requester 2.
    one(2, 16'h003F, 16'h0021);
    for (int i = 0; i < 3; i++) rnd(1'b0, 4'b0000, 1'b1);

    // All requesters continuously valid, consumer always ready.
    for (int i = 0; i < 10; i++) rnd(1'b0, 4'b1111, 1'b1);

    // Backpressure for 5 cycles, then release.
    for (int i = 0; i < 5; i++) rnd(1'b0, 4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) rnd(1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) rnd(1'b0, 4'b0000, 1'b1);

    // Zero and extreme operands.
    one(1, 16'h0000, 16'hFFFF);
    one(1, 16'h0001, 16'h0001);
    one(0, 16'hFFFF, 16'hFFFF);
    one(3, 16'h8000, 16'hFFFF);
    one(2, 16'hFFFF, 16'h0040);
    for (int i = 0; i < 3; i++) rnd(1'b0, 4'b0000, 1'b1);

    // Fairness: requester 0 hogs, requester 3 raises its request once.
    for (int i = 0; i < 3; i++) rnd(1'b0, 4'b0001, 1'b1);
    for (int i = 0; i < 2; i++) rnd(1'b0, 4'b1001, 1'b1);
    for (int i = 0; i < 4; i++) rnd(1'b0, 4'b0001, 1'b1);

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++)
      rnd(1'b0, 4'($urandom), 1'($urandom_range(0, 3) != 0));

    // Reset while both stages are full; nothing stale may appear afterwards.
    for (int i = 0; i < 3; i++) rnd(1'b0, 4'b1111, 1'b0);
    rnd(1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) rnd(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) rnd(1'b0, 4'b0110, 1'b1);

    // Drain.
    for (int i = 0; i < 5; i++) rnd(1'b0, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
